segre_dtlb_ptw: RTL and testbench
=================================

# segre_dtlb_ptw

Page-table walker for the data TLB: sits directly downstream of `segre_dtlb`, consuming its miss indication and virtual address, fetching the matching page-table entry from memory, and returning a refill (VPN→PPN) or a fault. It uses a single-level table of 32-bit PTEs indexed by VPN, 4 KB pages and a 20-bit physical address space. It holds one outstanding walk at a time.

## Interface
Parameters:
- `WORD_SIZE`, 32, virtual address and PTE width
- `PHYSICAL_ADDR_SIZE`, 20, physical address width
- `PAGE_OFFSET`, 12, page offset bits; VPN = 20 bits, PPN = 8 bits
- `TIMEOUT`, 64, max cycles waiting for memory data before fault

Ports:
- `clock_i` in 1: single clock, rising edge
- `rsn_i` in 1: reset, asynchronous, active-high
- `miss_i` in 1: TLB miss for `vaddr_i` (level; sampled only in IDLE)
- `vaddr_i` in WORD_SIZE: faulting virtual address
- `ptbr_i` in PHYSICAL_ADDR_SIZE: page-table base; bits [1:0] ignored (treated as 0)
- `flush_i` in 1: abort current walk
- `busy_o` out 1: high in every state except IDLE
- `mem_req_o` out 1: PTE read request
- `mem_addr_o` out PHYSICAL_ADDR_SIZE: PTE address
- `mem_gnt_i` in 1: request accepted this cycle
- `mem_valid_i` in 1: read data valid
- `mem_rdata_i` in WORD_SIZE: PTE
- `refill_valid_o` out 1: one-cycle refill pulse
- `refill_vpn_o` out 20: VPN being refilled
- `refill_ppn_o` out 8: PPN = PTE[19:12]
- `fault_o` out 1: one-cycle fault pulse (invalid PTE or timeout)

## Operation
- PTE format: bit 0 = V; bits [19:12] = PPN; others ignored.
- PTE address = (ptbr_i & ~3) + (VPN << 2), truncated mod 2^20 (wraps silently).
- States: IDLE, REQ, WAIT, DONE, FAULT, DRAIN.
- IDLE: if `miss_i` && !`flush_i`, latch VPN = `vaddr_i`[31:12] and PTE address (from `ptbr_i` at that cycle) → REQ.
- REQ: `mem_req_o`=1, `mem_addr_o` stable; on `mem_gnt_i` → WAIT, timeout counter cleared.
- WAIT: counter increments each cycle; on `mem_valid_i`: V=1 → DONE (latch PPN), V=0 → FAULT; else counter reaches TIMEOUT-1 → FAULT.
- DONE: `refill_valid_o`=1 with latched VPN/PPN → IDLE. FAULT: `fault_o`=1 → IDLE.
- `flush_i`: from REQ (no grant this cycle) or DONE/FAULT → IDLE with no pulse emitted. From REQ with simultaneous `mem_gnt_i`, or from WAIT without `mem_valid_i` → DRAIN. From WAIT with `mem_valid_i` same cycle → IDLE, data discarded.
- DRAIN: waits for `mem_valid_i` (data discarded) or timeout → IDLE; no pulses.
- `miss_i` outside IDLE ignored; miss and flush in IDLE together: flush wins.
- `mem_valid_i` on the same cycle as timeout expiry: data wins.
- `refill_vpn_o`/`refill_ppn_o` hold last latched values outside DONE.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (`busy_o`, `mem_req_o`, `mem_addr_o`, `refill_*`, `fault_o`).
- Reset mid-walk: immediate return to IDLE; any in-flight response after reset is ignored.
- Cycle 0 miss sampled; cycle 1 `mem_req_o`; grant at cycle g; data at cycle d>g; pulse at cycle d+1; IDLE at d+2. Minimum miss→refill = 3 cycles (grant cycle 1, data cycle 2).
- `mem_req_o` held continuously until granted; address never changes while requested.
- Outputs are registered or decoded from state only; no combinational path from `mem_*` inputs to outputs.
- Back-to-back walk: new miss accepted in the IDLE cycle following a pulse.

## Test plan
- Hit refill: ptbr=0x01000, vaddr=0x00003ABC, immediate grant, data 0x0005A001 next cycle → `mem_addr_o`=0x0100C, refill pulse VPN=0x00003, PPN=0x5A at cycle 3.
- Invalid PTE: data 0x0005A000 → `fault_o` one cycle, no `refill_valid_o`.
- Timeout: grant, never valid → `fault_o` exactly TIMEOUT cycles after entering WAIT; valid on the expiry cycle instead yields a refill.
- Address wrap: ptbr=0xFFFFC, VPN=0x00002 → `mem_addr_o`=0x00004; grant stall of 5 cycles keeps `mem_req_o`/address stable.
- Flush in WAIT: DRAIN, late valid discarded, no pulse, `busy_o` falls next cycle; flush+miss in IDLE → stays IDLE.
- Async reset asserted in WAIT → outputs 0 immediately; subsequent `mem_valid_i` causes no pulse.

Source files
------------

// File: rtl/segre_dtlb_ptw_if.sv
// Memory read port between the DTLB page-table walker and the memory system.
//   mem_req_o   : PTE read request (walker -> memory)
//   mem_addr_o  : PTE physical address (walker -> memory)
//   mem_gnt_i   : request accepted this cycle (memory -> walker)
//   mem_valid_i : read data valid (memory -> walker)
//   mem_rdata_i : PTE read data (memory -> walker)
// master = walker side, slave = memory side.
interface segre_dtlb_ptw_if #(
  parameter int WORD_SIZE          = 32,
  parameter int PHYSICAL_ADDR_SIZE = 20
);
  logic                          mem_req_o;
  logic [PHYSICAL_ADDR_SIZE-1:0] mem_addr_o;
  logic                          mem_gnt_i;
  logic                          mem_valid_i;
  logic [WORD_SIZE-1:0]          mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_valid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_valid_i, mem_rdata_i
  );
endinterface

// File: rtl/segre_dtlb_ptw.sv
// Data-TLB page-table walker. On a TLB miss it reads one 32-bit PTE from a
// single-level table (indexed by VPN, 4 KB pages) and returns either a refill
// (VPN -> PPN) or a fault. One walk outstanding at a time.
// Ports:
//   clock_i, rsn_i     : clock (rising edge), async active-high reset
//   miss_i, vaddr_i    : miss request and faulting virtual address
//   ptbr_i             : page-table base (bits [1:0] ignored)
//   flush_i            : abort the current walk
//   busy_o             : walker not idle
//   mem_if             : PTE read port (req/addr/gnt/valid/rdata)
//   refill_valid_o     : one-cycle refill pulse with refill_vpn_o/refill_ppn_o
//   fault_o            : one-cycle fault pulse (invalid PTE or timeout)
module segre_dtlb_ptw #(
  parameter int WORD_SIZE          = 32,
  parameter int PHYSICAL_ADDR_SIZE = 20,
  parameter int PAGE_OFFSET        = 12,
  parameter int TIMEOUT            = 64
) (
  input  logic                                  clock_i,
  input  logic                                  rsn_i,
  input  logic                                  miss_i,
  input  logic [WORD_SIZE-1:0]                  vaddr_i,
  input  logic [PHYSICAL_ADDR_SIZE-1:0]         ptbr_i,
  input  logic                                  flush_i,
  output logic                                  busy_o,
  segre_dtlb_ptw_if.master                      mem_if,
  output logic                                  refill_valid_o,
  output logic [WORD_SIZE-PAGE_OFFSET-1:0]      refill_vpn_o,
  output logic [PHYSICAL_ADDR_SIZE-PAGE_OFFSET-1:0] refill_ppn_o,
  output logic                                  fault_o
);
  localparam int VPN_W = WORD_SIZE - PAGE_OFFSET;
  localparam int PPN_W = PHYSICAL_ADDR_SIZE - PAGE_OFFSET;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_FAULT, S_DRAIN} state_t;

  state_t                        r_state, w_next;
  logic [CNT_W-1:0]              r_cnt;
  logic [VPN_W-1:0]              r_vpn;
  logic [PHYSICAL_ADDR_SIZE-1:0] r_addr;
  logic [VPN_W-1:0]              r_refill_vpn;
  logic [PPN_W-1:0]              r_refill_ppn;

  logic                          w_accept;
  logic                          w_timeout;
  logic                          w_pte_v;
  logic [VPN_W-1:0]              w_vpn;
  logic [PHYSICAL_ADDR_SIZE-1:0] w_pte_addr;
  logic                          w_busy, w_req, w_refill, w_fault;

  assign w_accept  = (r_state == S_IDLE) && miss_i && !flush_i;
  assign w_timeout = (r_cnt == CNT_LAST);
  assign w_pte_v   = mem_if.mem_rdata_i[0];
  assign w_vpn     = vaddr_i[WORD_SIZE-1:PAGE_OFFSET];
  // Base is word aligned; the sum is truncated to the physical width and wraps.
  assign w_pte_addr = {ptbr_i[PHYSICAL_ADDR_SIZE-1:2], 2'b00}
                    + {w_vpn[PHYSICAL_ADDR_SIZE-3:0], 2'b00};

  // State register
  always_ff @(posedge clock_i or posedge rsn_i) begin
    if (rsn_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ: begin
        // A granted request always produces a response, so a flush that
        // coincides with the grant has to drain it.
        if (mem_if.mem_gnt_i)  w_next = flush_i ? S_DRAIN : S_WAIT;
        else if (flush_i)      w_next = S_IDLE;
      end
      S_WAIT: begin
        if (flush_i)                 w_next = mem_if.mem_valid_i ? S_IDLE : S_DRAIN;
        else if (mem_if.mem_valid_i) w_next = w_pte_v ? S_DONE : S_FAULT;
        else if (w_timeout)          w_next = S_FAULT;
      end
      S_DONE, S_FAULT: w_next = S_IDLE;
      S_DRAIN: if (mem_if.mem_valid_i || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode (state only, plus flush suppression of the pulses)
  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_req    = (r_state == S_REQ);
    w_refill = (r_state == S_DONE)  && !flush_i;
    w_fault  = (r_state == S_FAULT) && !flush_i;
  end

  assign busy_o            = w_busy;
  assign mem_if.mem_req_o  = w_req;
  assign mem_if.mem_addr_o = r_addr;
  assign refill_valid_o    = w_refill;
  assign fault_o           = w_fault;
  assign refill_vpn_o      = r_refill_vpn;
  assign refill_ppn_o      = r_refill_ppn;

  // Timeout counter: restarts on every entry to WAIT or DRAIN so a drain
  // always gets a full timeout window of its own.
  always_ff @(posedge clock_i or posedge rsn_i) begin
    if (rsn_i) begin
      r_cnt <= '0;
    end else if ((w_next == S_WAIT || w_next == S_DRAIN) && (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Walk context; address only moves on acceptance, so it is stable during REQ.
  always_ff @(posedge clock_i or posedge rsn_i) begin
    if (rsn_i) begin
      r_vpn  <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_vpn  <= w_vpn;
      r_addr <= w_pte_addr;
    end
  end

  // Refill outputs update only when a valid PTE arrives, and hold otherwise.
  always_ff @(posedge clock_i or posedge rsn_i) begin
    if (rsn_i) begin
      r_refill_vpn <= '0;
      r_refill_ppn <= '0;
    end else if (r_state == S_WAIT && w_next == S_DONE) begin
      r_refill_vpn <= r_vpn;
      r_refill_ppn <= mem_if.mem_rdata_i[PHYSICAL_ADDR_SIZE-1:PAGE_OFFSET];
    end
  end

  logic w_unused;
  assign w_unused = ^{ptbr_i[1:0], vaddr_i[PAGE_OFFSET-1:0],
                      mem_if.mem_rdata_i[WORD_SIZE-1:PHYSICAL_ADDR_SIZE],
                      mem_if.mem_rdata_i[PAGE_OFFSET-1:1]};
endmodule

// File: tb/tb_segre_dtlb_ptw.sv
module tb_segre_dtlb_ptw;
  logic        clock_i, rsn_i, miss_i, flush_i;
  logic [31:0] vaddr_i;
  logic [19:0] ptbr_i;
  logic        busy_o, refill_valid_o, fault_o;
  logic [19:0] refill_vpn_o;
  logic [7:0]  refill_ppn_o;

  segre_dtlb_ptw_if #(.WORD_SIZE(32), .PHYSICAL_ADDR_SIZE(20)) mif();

  segre_dtlb_ptw #(.WORD_SIZE(32), .PHYSICAL_ADDR_SIZE(20), .PAGE_OFFSET(12), .TIMEOUT(64)) dut (
    .clock_i(clock_i), .rsn_i(rsn_i), .miss_i(miss_i), .vaddr_i(vaddr_i),
    .ptbr_i(ptbr_i), .flush_i(flush_i), .busy_o(busy_o), .mem_if(mif),
    .refill_valid_o(refill_valid_o), .refill_vpn_o(refill_vpn_o),
    .refill_ppn_o(refill_ppn_o), .fault_o(fault_o)
  );

  typedef struct {
    bit         fault;
    logic [19:0] vpn;
    logic [7:0]  ppn;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i); #1;
  endtask

  task automatic start_miss(input logic [19:0] ptbr, input logic [31:0] va);
    ptbr_i = ptbr; vaddr_i = va; miss_i = 1'b1;
    tick();
    miss_i = 1'b0;
  endtask

  task automatic push(input bit f, input logic [19:0] vpn, input logic [7:0] ppn);
    exp_t e;
    e.fault = f; e.vpn = vpn; e.ppn = ppn;
    sb.push_back(e);
  endtask

  // Scoreboard: every pulse must match the oldest expected result.
  always @(negedge clock_i) begin
    if (!rsn_i && (refill_valid_o || fault_o)) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pulse observed=refill%0b/fault%0b expected=none", refill_valid_o, fault_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_fault", {31'd0, fault_o}, {31'd0, e.fault});
        chk("sb_refill", {31'd0, refill_valid_o}, {31'd0, !e.fault});
        if (!e.fault) begin
          chk("sb_vpn", {12'd0, refill_vpn_o}, {12'd0, e.vpn});
          chk("sb_ppn", {24'd0, refill_ppn_o}, {24'd0, e.ppn});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rsn_i = 1'b1; miss_i = 0; flush_i = 0; vaddr_i = 0; ptbr_i = 0;
    mif.mem_gnt_i = 0; mif.mem_valid_i = 0; mif.mem_rdata_i = 0;
    #3;
    // Reset state
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_req", {31'd0, mif.mem_req_o}, 0);
    chk("rst_addr", {12'd0, mif.mem_addr_o}, 0);
    chk("rst_refill", {31'd0, refill_valid_o}, 0);
    chk("rst_vpn", {12'd0, refill_vpn_o}, 0);
    chk("rst_ppn", {24'd0, refill_ppn_o}, 0);
    chk("rst_fault", {31'd0, fault_o}, 0);
    #9 rsn_i = 1'b0;
    tick();

    // Hit refill, minimum latency
    start_miss(20'h01000, 32'h0000_3ABC);
    chk("hit_req", {31'd0, mif.mem_req_o}, 1);
    chk("hit_addr", {12'd0, mif.mem_addr_o}, 32'h0100C);
    chk("hit_busy", {31'd0, busy_o}, 1);
    push(0, 20'h00003, 8'h5A);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0; mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h0005A001;
    chk("hit_req_drop", {31'd0, mif.mem_req_o}, 0);
    tick();
    mif.mem_valid_i = 0;
    chk("hit_pulse_c3", {31'd0, refill_valid_o}, 1);
    tick();
    chk("hit_idle", {31'd0, busy_o}, 0);
    chk("hit_pulse_end", {31'd0, refill_valid_o}, 0);
    chk("hit_vpn_hold", {12'd0, refill_vpn_o}, 32'h00003);

    // Invalid PTE, started back-to-back in the IDLE cycle after the pulse
    start_miss(20'h01000, 32'h0000_3ABC);
    chk("b2b_busy", {31'd0, busy_o}, 1);
    push(1, 0, 0);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0; mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h0005A000;
    tick();
    mif.mem_valid_i = 0;
    chk("inv_fault", {31'd0, fault_o}, 1);
    chk("inv_norefill", {31'd0, refill_valid_o}, 0);
    tick();
    chk("inv_fault_end", {31'd0, fault_o}, 0);

    // Timeout: fault exactly 64 cycles after entering WAIT
    start_miss(20'h01000, 32'h0000_5000);
    push(1, 0, 0);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0;
    repeat (63) tick();
    chk("to_not_yet", {31'd0, fault_o}, 0);
    chk("to_busy", {31'd0, busy_o}, 1);
    tick();
    chk("to_fault", {31'd0, fault_o}, 1);
    tick();
    chk("to_idle", {31'd0, busy_o}, 0);

    // Data on the expiry cycle wins over timeout
    start_miss(20'h01000, 32'h1234_5678);
    chk("exp_addr", {12'd0, mif.mem_addr_o}, 32'h49D14);
    push(0, 20'h12345, 8'h77);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0;
    repeat (63) tick();
    mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h0007_7001;
    tick();
    mif.mem_valid_i = 0;
    chk("exp_refill", {31'd0, refill_valid_o}, 1);
    chk("exp_nofault", {31'd0, fault_o}, 0);
    tick();

    // Address wrap and grant stall; inputs change during the stall
    start_miss(20'hFFFFC, 32'h0000_2000);
    ptbr_i = 20'h0AAA0; vaddr_i = 32'hFFFF_F000; miss_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk("wrap_req", {31'd0, mif.mem_req_o}, 1);
      chk("wrap_addr", {12'd0, mif.mem_addr_o}, 32'h00004);
      tick();
    end
    miss_i = 0;
    push(0, 20'h00002, 8'hAB);
    mif.mem_gnt_i = 1;
    chk("wrap_addr_gnt", {12'd0, mif.mem_addr_o}, 32'h00004);
    tick();
    mif.mem_gnt_i = 0; mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h000A_B001;
    tick();
    mif.mem_valid_i = 0;
    chk("wrap_refill", {31'd0, refill_valid_o}, 1);
    tick();

    // Flush in WAIT -> DRAIN, late data discarded
    start_miss(20'h02000, 32'h0000_1000);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0;
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("drain_busy", {31'd0, busy_o}, 1);
    tick();
    mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h0005A001;
    tick();
    mif.mem_valid_i = 0;
    chk("drain_done", {31'd0, busy_o}, 0);
    chk("drain_nopulse", {31'd0, refill_valid_o}, 0);

    // Flush and miss together in IDLE
    miss_i = 1; flush_i = 1;
    tick();
    miss_i = 0; flush_i = 0;
    chk("flushmiss_idle", {31'd0, busy_o}, 0);
    chk("flushmiss_noreq", {31'd0, mif.mem_req_o}, 0);

    // Async reset in WAIT
    start_miss(20'h01000, 32'h0000_3ABC);
    mif.mem_gnt_i = 1;
    tick();
    mif.mem_gnt_i = 0;
    #1 rsn_i = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy_o}, 0);
    chk("arst_addr", {12'd0, mif.mem_addr_o}, 0);
    chk("arst_vpn", {12'd0, refill_vpn_o}, 0);
    #1 rsn_i = 1'b0;
    mif.mem_valid_i = 1; mif.mem_rdata_i = 32'h0005A001;
    tick();
    mif.mem_valid_i = 0;
    tick();
    chk("arst_nopulse", {31'd0, refill_valid_o}, 0);
    chk("arst_idle", {31'd0, busy_o}, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
